// File: rtl/i_decode_if.sv
// IF/ID -> ID/EX bus for the decode stage, including the WB-stage register write port.
interface i_decode_if;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_NPC;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic [31:0] npcout;
  logic [31:0] rdata1out;
  logic [31:0] rdata2out;
  logic [31:0] s_extendout;
  logic [4:0]  instrout_2016;
  logic [4:0]  instrout_1511;
  logic [3:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [1:0]  ex_ctlout;

  modport master (
    output IF_ID_instr, IF_ID_NPC, regwrite, rd, writedata,
    input  npcout, rdata1out, rdata2out, s_extendout,
           instrout_2016, instrout_1511, wb_ctlout, m_ctlout, ex_ctlout
  );

  modport slave (
    input  IF_ID_instr, IF_ID_NPC, regwrite, rd, writedata,
    output npcout, rdata1out, rdata2out, s_extendout,
           instrout_2016, instrout_1511, wb_ctlout, m_ctlout, ex_ctlout
  );
endinterface

// File: rtl/i_decode.sv
// MIPS ID stage: control decode, 32x32 register file, sign extension, ID/EX register.
// Define ID_WRITE_BYPASS_EN for write-first regfile reads (default is read-first).
module i_decode (
  input  logic       clk,
  input  logic       rst,
  i_decode_if.slave  bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  logic [31:0] regs_q [32];

  logic [4:0]  rs, rt;
  logic [31:0] rdata1_d, rdata2_d;
  logic [3:0]  wb_d;
  logic [2:0]  m_d;
  logic [1:0]  ex_d;
  logic        wr_en;

  logic [31:0] npc_q, rdata1_q, rdata2_q, sext_q;
  logic [4:0]  rt_q, rdst_q;
  logic [3:0]  wb_q;
  logic [2:0]  m_q;
  logic [1:0]  ex_q;

  assign rs    = bus.IF_ID_instr[25:21];
  assign rt    = bus.IF_ID_instr[20:16];
  assign wr_en = bus.regwrite && (bus.rd != 5'd0);

  always_comb begin
    wb_d = '0;
    m_d  = '0;
    ex_d = '0;
    case (bus.IF_ID_instr[31:26])
      OP_RTYPE: begin wb_d = 4'b1010; m_d = 3'b000; ex_d = 2'b10; end
      OP_LW:    begin wb_d = 4'b0111; m_d = 3'b010; ex_d = 2'b00; end
      OP_SW:    begin wb_d = 4'b0100; m_d = 3'b001; ex_d = 2'b00; end
      OP_BEQ:   begin wb_d = 4'b0000; m_d = 3'b100; ex_d = 2'b01; end
      default:  ;
    endcase
  end

  always_comb begin
    rdata1_d = (rs == 5'd0) ? '0 : regs_q[rs];
    rdata2_d = (rt == 5'd0) ? '0 : regs_q[rt];
`ifdef ID_WRITE_BYPASS_EN
    // Forward the WB write into the same-edge capture so reads see it immediately.
    if (wr_en && (bus.rd == rs)) rdata1_d = bus.writedata;
    if (wr_en && (bus.rd == rt)) rdata2_d = bus.writedata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.rd] <= bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      npc_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      sext_q   <= '0;
      rt_q     <= '0;
      rdst_q   <= '0;
      wb_q     <= '0;
      m_q      <= '0;
      ex_q     <= '0;
    end else begin
      npc_q    <= bus.IF_ID_NPC;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      sext_q   <= {{16{bus.IF_ID_instr[15]}}, bus.IF_ID_instr[15:0]};
      rt_q     <= bus.IF_ID_instr[20:16];
      rdst_q   <= bus.IF_ID_instr[15:11];
      wb_q     <= wb_d;
      m_q      <= m_d;
      ex_q     <= ex_d;
    end
  end

  assign bus.npcout        = npc_q;
  assign bus.rdata1out     = rdata1_q;
  assign bus.rdata2out     = rdata2_q;
  assign bus.s_extendout   = sext_q;
  assign bus.instrout_2016 = rt_q;
  assign bus.instrout_1511 = rdst_q;
  assign bus.wb_ctlout     = wb_q;
  assign bus.m_ctlout      = m_q;
  assign bus.ex_ctlout     = ex_q;

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: directed test-plan sequence plus randomized traffic against a
// register-array reference model. Honors ID_WRITE_BYPASS_EN like the design.
module tb_i_decode;

  logic clk = 1'b0;
  logic rst = 1'b0;

  i_decode_if bus ();

  i_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] model_rf [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return {4'b1010, 3'b000, 2'b10};
      6'h23:   return {4'b0111, 3'b010, 2'b00};
      6'h2B:   return {4'b0100, 3'b001, 2'b00};
      6'h04:   return {4'b0000, 3'b100, 2'b01};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic w,
                                             input logic [4:0] d, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
`ifdef ID_WRITE_BYPASS_EN
    if (w && d == idx) return wd;
`endif
    return model_rf[idx];
  endfunction

  // Drive one instruction, clock it in, update the model, check every output.
  task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] npc,
                       input logic w, input logic [4:0] d, input logic [31:0] wd);
    logic [31:0] e_npc, e_r1, e_r2, e_sx;
    logic [4:0]  e_rt, e_rd;
    logic [8:0]  e_ctl;
    rst = r;
    bus.IF_ID_instr = ins;
    bus.IF_ID_NPC   = npc;
    bus.regwrite    = w;
    bus.rd          = d;
    bus.writedata   = wd;
    if (r) begin
      e_npc = 0; e_r1 = 0; e_r2 = 0; e_sx = 0; e_rt = 0; e_rd = 0; e_ctl = 0;
    end else begin
      e_npc = npc;
      e_r1  = model_read(ins[25:21], w, d, wd);
      e_r2  = model_read(ins[20:16], w, d, wd);
      e_sx  = 32'($signed(ins[15:0]));
      e_rt  = ins[20:16];
      e_rd  = ins[15:11];
      e_ctl = ctl_of(ins[31:26]);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    end else if (w && d != 5'd0) begin
      model_rf[d] = wd;
    end
    #1;
    check("npcout",        bus.npcout,        e_npc);
    check("rdata1out",     bus.rdata1out,     e_r1);
    check("rdata2out",     bus.rdata2out,     e_r2);
    check("s_extendout",   bus.s_extendout,   e_sx);
    check("instrout_2016", 32'(bus.instrout_2016), 32'(e_rt));
    check("instrout_1511", 32'(bus.instrout_1511), 32'(e_rd));
    check("wb_ctlout",     32'(bus.wb_ctlout), 32'(e_ctl[8:5]));
    check("m_ctlout",      32'(bus.m_ctlout),  32'(e_ctl[4:2]));
    check("ex_ctlout",     32'(bus.ex_ctlout), 32'(e_ctl[1:0]));
  endtask

  initial begin
    logic [31:0] ins, wd;
    logic [4:0]  d;
    logic        w, r;
    logic [5:0]  ops [6];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F; ops[5] = 6'h08;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    @(negedge clk);
    cycle(1'b1, 32'h036E8B6C, 32'h00000ABC, 1'b0, 5'd0, 32'd0);
    check("reset_npc", bus.npcout, 32'd0);
    check("reset_wb", 32'(bus.wb_ctlout), 32'd0);

    cycle(1'b0, 32'h036E8B6C, 32'h00000ABC, 1'b0, 5'd0, 32'd0);
    check("rtype_npc", bus.npcout, 32'h00000ABC);
    check("rtype_sext", bus.s_extendout, 32'hFFFF8B6C);
    check("rtype_rt", 32'(bus.instrout_2016), 32'd14);
    check("rtype_rd", 32'(bus.instrout_1511), 32'd17);
    check("rtype_wb", 32'(bus.wb_ctlout), 32'b1010);
    check("rtype_ex", 32'(bus.ex_ctlout), 32'b10);

    cycle(1'b0, 32'h036E8B6C, 32'h00000ABC, 1'b1, 5'd27, 32'd12);
    cycle(1'b0, 32'h036E8B6C, 32'h00000ABC, 1'b0, 5'd14, 32'd14);
    check("wr_then_rd_r27", bus.rdata1out, 32'd12);
    check("never_written_r14", bus.rdata2out, 32'd0);

    cycle(1'b0, 32'h8F6E8B6C, 32'h00000AC0, 1'b0, 5'd0, 32'd0);
    check("lw_ctl", {bus.wb_ctlout, bus.m_ctlout, bus.ex_ctlout}, {23'd0, 4'b0111, 3'b010, 2'b00});
    cycle(1'b0, 32'hAF6E8B6C, 32'h00000AC4, 1'b0, 5'd0, 32'd0);
    check("sw_ctl", {bus.wb_ctlout, bus.m_ctlout, bus.ex_ctlout}, {23'd0, 4'b0100, 3'b001, 2'b00});
    cycle(1'b0, 32'h136E8B6C, 32'h00000AC8, 1'b0, 5'd0, 32'd0);
    check("beq_ctl", {bus.wb_ctlout, bus.m_ctlout, bus.ex_ctlout}, {23'd0, 4'b0000, 3'b100, 2'b01});

    cycle(1'b0, 32'hFC00FFFF, 32'h00000ACC, 1'b0, 5'd0, 32'd0);
    check("unknown_op_ctl", {bus.wb_ctlout, bus.m_ctlout, bus.ex_ctlout}, 32'd0);
    cycle(1'b0, 32'hFC00FFFF, 32'h00000AD0, 1'b1, 5'd0, 32'hFFFFFFFF);
    cycle(1'b0, 32'hFC00FFFF, 32'h00000AD4, 1'b0, 5'd0, 32'd0);
    check("r0_stays_zero", bus.rdata1out, 32'd0);

    cycle(1'b0, 32'h036E8B6C, 32'h00000AD8, 1'b1, 5'd27, 32'h55);
`ifdef ID_WRITE_BYPASS_EN
    check("same_cycle_rs27", bus.rdata1out, 32'h55);
`else
    check("same_cycle_rs27", bus.rdata1out, 32'd12);
`endif
    cycle(1'b0, 32'h036E8B6C, 32'h00000ADC, 1'b0, 5'd0, 32'd0);
    check("next_cycle_rs27", bus.rdata1out, 32'h55);

    cycle(1'b0, 32'h00A00000, 32'h00000AE0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle(1'b1, 32'h00A00000, 32'h00000AE4, 1'b1, 5'd5, 32'h12345678);
    check("rst_prio_out", bus.rdata1out, 32'd0);
    cycle(1'b0, 32'h00A00000, 32'h00000AE8, 1'b0, 5'd0, 32'd0);
    check("rst_prio_r5", bus.rdata1out, 32'd0);
    cycle(1'b0, 32'h036E8B6C, 32'h00000AEC, 1'b0, 5'd0, 32'd0);
    check("rst_cleared_r27", bus.rdata1out, 32'd0);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(5)];
      r  = ($urandom_range(39) == 0);
      w  = ($urandom_range(2) != 0);
      wd = $urandom;
      case ($urandom_range(3))
        0:       d = ins[25:21];
        1:       d = ins[20:16];
        default: d = 5'($urandom_range(31));
      endcase
      cycle(r, ins, $urandom, w, d, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
